// File: rtl/cache_fill_ctrl.sv
// Direct-mapped, 4-line x 8-byte cache fill controller.
// On a miss it fetches the whole line byte by byte (offsets 0..7) from backing
// memory, writing each byte into the data array, then commits tag and valid.
// Optional feature: define CACHE_FLUSH_EN to add the flush input, which
// invalidates every line (deferred until after the commit if a fill is running).
module cache_fill_ctrl #(
  parameter int unsigned ADDR_WIDTH = 12,
  parameter int unsigned TAG_WIDTH  = ADDR_WIDTH - 5
) (
  input  logic                  clk,
  input  logic                  reset_n,
`ifdef CACHE_FLUSH_EN
  input  logic                  flush,
`endif
  input  logic                  req,
  input  logic [ADDR_WIDTH-1:0] addr,
  output logic                  hit,
  output logic                  stall,
  output logic [1:0]            rdline,
  output logic [2:0]            rdoffset,
  output logic [1:0]            wrline,
  output logic [2:0]            wroffset,
  output logic [7:0]            wrdata,
  output logic                  wren,
  output logic                  mem_rd,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [7:0]            mem_data,
  input  logic                  mem_ack
);

  typedef enum logic [1:0] {StIdle, StFetch, StCommit} state_e;

  state_e               state_q, state_d;
  logic [3:0]           valid_q, valid_d;
  logic [TAG_WIDTH-1:0] tag_q [4];
  logic [TAG_WIDTH-1:0] fill_tag_q;
  logic [1:0]           fill_line_q;
  logic [2:0]           cnt_q;
  logic                 mem_rd_q;
  logic [ADDR_WIDTH-1:0] mem_addr_q;

  logic [TAG_WIDTH-1:0] addr_tag;
  logic [1:0]           addr_line;
  logic                 miss_start;
  logic                 ack_take;
  logic                 last_ack;

`ifdef CACHE_FLUSH_EN
  logic flush_pend_q, flush_pend_d;
`endif

  assign addr_tag  = addr[ADDR_WIDTH-1:5];
  assign addr_line = addr[4:3];
  assign rdline    = addr[4:3];
  assign rdoffset  = addr[2:0];
  assign mem_rd    = mem_rd_q;
  assign mem_addr  = mem_addr_q;

  // Lookup: hits are only reported while idle so a fill in progress always stalls.
  always_comb begin
    hit = req & valid_q[addr_line] & (tag_q[addr_line] == addr_tag) & (state_q == StIdle);
`ifdef CACHE_FLUSH_EN
    if (flush) hit = 1'b0;
`endif
    stall = req & ~hit;
  end

  // Fill events: start of a miss, an accepted memory byte, and the final byte.
  always_comb begin
    miss_start = (state_q == StIdle) & stall;
    ack_take   = (state_q == StFetch) & mem_rd_q & mem_ack;
    last_ack   = ack_take & (cnt_q == 3'd7);
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (miss_start) state_d = StFetch;
      StFetch:  if (last_ack) state_d = StCommit;
      StCommit: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= StIdle;
    else          state_q <= state_d;
  end

  // Valid-bit next state: clear on miss, set on commit, flush overrides both.
  always_comb begin
    valid_d = valid_q;
    if (miss_start) valid_d[addr_line] = 1'b0;
    if (state_q == StCommit) valid_d[fill_line_q] = 1'b1;
`ifdef CACHE_FLUSH_EN
    flush_pend_d = flush_pend_q;
    if (state_q == StCommit) begin
      flush_pend_d = 1'b0;
      if (flush_pend_q || flush) valid_d = '0;
    end else if (state_q == StFetch) begin
      if (flush) flush_pend_d = 1'b1;
    end else if (flush) begin
      valid_d = '0;
    end
`endif
  end

  // Valid bits and tags.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= '0;
      for (int i = 0; i < 4; i++) tag_q[i] <= '0;
    end else begin
      valid_q <= valid_d;
      if (state_q == StCommit) tag_q[fill_line_q] <= fill_tag_q;
    end
  end

`ifdef CACHE_FLUSH_EN
  // Flush requested mid-fill is held until the commit.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) flush_pend_q <= 1'b0;
    else          flush_pend_q <= flush_pend_d;
  end
`endif

  // Fill sequencer: captures the missing line and walks cnt through the bytes.
  // After each ack mem_rd drops for one cycle, then the next byte is requested.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fill_tag_q  <= '0;
      fill_line_q <= '0;
      cnt_q       <= '0;
      mem_rd_q    <= 1'b0;
      mem_addr_q  <= '0;
    end else if (miss_start) begin
      fill_tag_q  <= addr_tag;
      fill_line_q <= addr_line;
      cnt_q       <= '0;
      mem_rd_q    <= 1'b1;
      mem_addr_q  <= {addr_tag, addr_line, 3'd0};
    end else if (state_q == StFetch) begin
      if (ack_take) begin
        mem_rd_q <= 1'b0;
        if (!last_ack) begin
          cnt_q      <= cnt_q + 3'd1;
          mem_addr_q <= {fill_tag_q, fill_line_q, cnt_q + 3'd1};
        end
      end else if (!mem_rd_q) begin
        mem_rd_q <= 1'b1;
      end
    end
  end

  // Data-array write port: one registered pulse per accepted byte.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wren     <= 1'b0;
      wrdata   <= '0;
      wrline   <= '0;
      wroffset <= '0;
    end else begin
      wren <= ack_take;
      if (ack_take) begin
        wrdata   <= mem_data;
        wrline   <= fill_line_q;
        wroffset <= cnt_q;
      end
    end
  end

endmodule

// File: tb/tb_cache_fill_ctrl.sv
// Scoreboard bench for cache_fill_ctrl: stimulus pushes expected memory
// addresses, data-array writes and lookup outcomes; a monitor pops and compares.
module tb_cache_fill_ctrl;
  localparam int AW = 12;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          req;
  logic [AW-1:0] addr;
  logic          hit, stall;
  logic [1:0]    rdline, wrline;
  logic [2:0]    rdoffset, wroffset;
  logic [7:0]    wrdata, mem_data;
  logic          wren, mem_rd, mem_ack;
  logic [AW-1:0] mem_addr;
`ifdef CACHE_FLUSH_EN
  logic          flush = 1'b0;
`endif

  always #5 clk = ~clk;

  cache_fill_ctrl #(.ADDR_WIDTH(AW)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
`ifdef CACHE_FLUSH_EN
    .flush    (flush),
`endif
    .req      (req),
    .addr     (addr),
    .hit      (hit),
    .stall    (stall),
    .rdline   (rdline),
    .rdoffset (rdoffset),
    .wrline   (wrline),
    .wroffset (wroffset),
    .wrdata   (wrdata),
    .wren     (wren),
    .mem_rd   (mem_rd),
    .mem_addr (mem_addr),
    .mem_data (mem_data),
    .mem_ack  (mem_ack)
  );

  typedef struct {
    logic [AW-1:0] a;
    bit            exp_hit;
    int            exp_lat;   // cycles from first req to hit; -1 = not checked
  } txn_t;

  int n_cmp = 0;
  int n_bad = 0;
  int delay_mode = 0;         // 0: ack at once, 1: 3-cycle delay, 2: random 0..3
  int wren_cnt = 0;

  txn_t           txn_q[$];
  logic [AW-1:0]  exp_addr_q[$];
  logic [12:0]    exp_wr_q[$];
  bit             model_valid[4];
  logic [AW-6:0]  model_tag[4];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic finish_run();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  endtask

  function automatic logic [7:0] mem_byte(input logic [AW-1:0] a);
    return 8'((a * 37) ^ (a >> 3) ^ 8'h5a);
  endfunction

  // Backing memory: answers each mem_rd after a mode-dependent delay.
  initial begin
    int dly;
    dly = 0;
    mem_ack = 1'b0;
    mem_data = '0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        mem_ack = 1'b0;
        dly = 0;
      end else if (mem_ack) begin
        mem_ack = 1'b0;
        mem_data = 8'($urandom);
        dly = (delay_mode == 0) ? 0 : (delay_mode == 1) ? 3 : int'($urandom_range(0, 3));
      end else if (mem_rd && dly == 0) begin
        mem_ack = 1'b1;
        mem_data = mem_byte(mem_addr);
      end else begin
        if (mem_rd) dly--;
        mem_data = 8'($urandom);
      end
    end
  end

  // Monitor: compares everything the DUT presents against the queues.
  initial begin
    bit   in_txn, prev_hs;
    int   lat;
    txn_t cur;
    in_txn = 0;
    prev_hs = 0;
    lat = 0;
    forever begin
      @(negedge clk);
      #2;
      if (!reset_n) begin
        in_txn = 0;
        prev_hs = 0;
        continue;
      end
      check("wren_only_after_ack", wren, prev_hs);
      if (wren) begin
        wren_cnt++;
        if (exp_wr_q.size() == 0) check("unexpected_write", 1, 0);
        else check("write_port", {wrline, wroffset, wrdata}, exp_wr_q.pop_front());
      end
      if (mem_rd) begin
        if (exp_addr_q.size() == 0) check("unexpected_mem_rd", 1, 0);
        else begin
          check("mem_addr", mem_addr, exp_addr_q[0]);
          if (mem_ack) void'(exp_addr_q.pop_front());
        end
      end
      prev_hs = mem_rd && mem_ack;
      if (req && !in_txn) begin
        if (txn_q.size() == 0) check("unexpected_req", 1, 0);
        else begin
          cur = txn_q.pop_front();
          in_txn = 1;
          lat = 0;
          check("hit_first_cycle", hit, cur.exp_hit);
          check("stall_first_cycle", stall, !cur.exp_hit);
          check("rdline", rdline, cur.a[4:3]);
          check("rdoffset", rdoffset, cur.a[2:0]);
        end
      end else if (in_txn) begin
        lat++;
      end
      if (in_txn && hit) begin
        if (cur.exp_lat >= 0) check("hit_latency", lat, cur.exp_lat);
        check("stall_on_hit", stall, 0);
        in_txn = 0;
      end
    end
  end

  task automatic push_fill(input logic [AW-1:0] a);
    logic [AW-1:0] fa;
    for (int i = 0; i < 8; i++) begin
      fa = {a[AW-1:3], 3'(i)};
      exp_addr_q.push_back(fa);
      exp_wr_q.push_back({a[4:3], 3'(i), mem_byte(fa)});
    end
  endtask

  // Predict the lookup from the model, update the model, then drive the request.
  task automatic start_txn(input logic [AW-1:0] a, input int miss_lat);
    txn_t t;
    bit   h;
    h = model_valid[a[4:3]] && (model_tag[a[4:3]] == a[AW-1:5]);
    if (!h) begin
      push_fill(a);
      model_valid[a[4:3]] = 1;
      model_tag[a[4:3]] = a[AW-1:5];
    end
    t.a = a;
    t.exp_hit = h;
    t.exp_lat = h ? 0 : miss_lat;
    @(posedge clk);
    #1;
    txn_q.push_back(t);
    req = 1'b1;
    addr = a;
  endtask

  task automatic wait_hit();
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      #3;
      if (hit) break;
    end
    if (!hit) begin
      check("hit_timeout", 0, 1);
      finish_run();
    end
    @(posedge clk);
    #1;
    req = 1'b0;
    addr = AW'($urandom);
  endtask

  task automatic wait_wren(input int target);
    for (int i = 0; i < 400; i++) begin
      if (wren_cnt >= target) break;
      @(negedge clk);
      #3;
    end
    if (wren_cnt < target) begin
      check("wren_timeout", 0, 1);
      finish_run();
    end
  endtask

  task automatic issue(input logic [AW-1:0] a, input int miss_lat);
    start_txn(a, miss_lat);
    wait_hit();
  endtask

  task automatic model_clear();
    for (int i = 0; i < 4; i++) model_valid[i] = 0;
  endtask

  initial begin
    int fl;
    logic [AW-1:0] ra;
    model_clear();
    reset_n = 1'b0;
    req = 1'b1;
    addr = '0;
    #3;
    check("reset_hit", hit, 0);
    check("reset_stall", stall, 1);
    check("reset_wren", wren, 0);
    check("reset_mem_rd", mem_rd, 0);
    check("reset_mem_addr", mem_addr, 0);
    check("reset_wrdata", wrdata, 0);
    check("reset_wrline", wrline, 0);
    check("reset_wroffset", wroffset, 0);
    req = 1'b0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;

    // Cold miss, hit, conflict refill, and the evicted address missing again.
    issue(12'h123, 17);
    issue(12'h125, 17);
    issue(12'h923, 17);
    issue(12'h123, 17);
    issue(12'h35a, 17);

    // Slow memory: requests must hold until each delayed ack.
    delay_mode = 1;
    issue(12'h3f0, -1);
    issue(12'h3f7, -1);
    issue(12'h0d1, -1);
    delay_mode = 0;
    issue(12'h200, -1);

    // Reset after four bytes of a fill; the line is refilled from offset 0.
    issue(12'h2a8, 17);
    issue(12'h6a8, 17);
    fl = wren_cnt;
    start_txn(12'h2a8, 17);
    wait_wren(fl + 4);
    reset_n = 1'b0;
    #1;
    check("midfill_reset_wren", wren, 0);
    check("midfill_reset_mem_rd", mem_rd, 0);
    check("midfill_reset_mem_addr", mem_addr, 0);
    check("midfill_reset_hit", hit, 0);
    exp_addr_q.delete();
    exp_wr_q.delete();
    txn_q.delete();
    model_clear();
    req = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    issue(12'h2a8, 17);
    issue(12'h2af, 17);

`ifdef CACHE_FLUSH_EN
    // Flush while idle invalidates everything.
    issue(12'h040, 17);
    @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    model_clear();
    // Flush during the fill of 0x040: the line ends invalid, so the held
    // request misses again and needs a second full fill.
    begin
      txn_t t;
      push_fill(12'h040);
      push_fill(12'h040);
      t.a = 12'h040;
      t.exp_hit = 0;
      t.exp_lat = 34;
      fl = wren_cnt;
      @(posedge clk);
      #1;
      txn_q.push_back(t);
      req = 1'b1;
      addr = 12'h040;
      wait_wren(fl + 3);
      @(posedge clk);
      #1;
      flush = 1'b1;
      @(posedge clk);
      #1;
      flush = 1'b0;
      model_clear();
      model_valid[0] = 1;
      model_tag[0] = 12'h040 >> 5;
      wait_hit();
    end
    issue(12'h043, 17);
`endif

    // Randomized traffic over a small tag set so hits and conflicts both occur.
    for (int n = 0; n < 60; n++) begin
      delay_mode = int'($urandom_range(0, 2));
      ra = {7'($urandom_range(0, 3)), 5'($urandom)};
      issue(ra, -1);
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end

    repeat (4) @(posedge clk);
    check("leftover_mem_addrs", exp_addr_q.size(), 0);
    check("leftover_writes", exp_wr_q.size(), 0);
    check("leftover_txns", txn_q.size(), 0);
    finish_run();
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got running, expected done");
    $fatal(1, "watchdog");
  end

endmodule
